ibr_multi: RTL
==============

# ibr_multi

Parametrised multi-lane integer branch resolution unit for the EX cluster. Resolves up to NUM_LANES conditional branches, JAL and JALR per cycle. Each lane's true target is compared against the front-end predicted target, and link values are produced for jumps. When lanes mispredict, the oldest mispredict is arbitrated and issued as a registered redirect. A flush state machine suppresses younger branches until the ROB signals flush completion.

## Interface
Parameters:
- NUM_LANES, 2, branch lanes per cycle (1..4)
- XLEN, 64, source operand / link width
- PADDR_W, 64, PC and target width
- ROBID_W, 7, ROB id width; the MSB is the wrap bit

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-low (0 = in reset)
- iss_vld_ex0  in  NUM_LANES  lane valid
- iss_kind_ex0  in  2*NUM_LANES  per lane: 0=BR, 1=JAL, 2=JALR, 3=reserved (treated as not valid)
- iss_funct3_ex0  in  3*NUM_LANES  branch condition, RV encoding
- iss_pc_ex0  in  PADDR_W*NUM_LANES  instruction PC
- iss_imm_ex0  in  PADDR_W*NUM_LANES  sign-extended immediate
- iss_pred_tgt_ex0  in  PADDR_W*NUM_LANES  front-end predicted next PC
- iss_robid_ex0  in  ROBID_W*NUM_LANES  ROB id
- src1_ex0, src2_ex0  in  XLEN*NUM_LANES  operands
- flush_done  in  1  pulse from ROB: redirect drained
- resvld_ex1  out  NUM_LANES  lane result valid
- link_ex1  out  XLEN*NUM_LANES  pc+4 for JAL/JALR, else 0
- mispred_vld_ex1  out  1  redirect valid (1-cycle pulse)
- mispred_tgt_ex1  out  PADDR_W  redirect address
- mispred_robid_ex1  out  ROBID_W  mispredicting branch ROB id
- flushing  out  1  flush state indicator

## Operation
- Per-lane EX0 computation:
  - pcnxt = pc+4.
  - BR: taken per funct3. BEQ/BNE test equality. BLT/BGE use signed XLEN compare. BLTU/BGEU use unsigned compare. funct3 010/011 = not taken. True target = taken ? pc+imm : pcnxt.
  - JAL: target = pc+imm.
  - JALR: target = (src1+imm) with bit0 cleared.
  - All address arithmetic is modulo 2^PADDR_W.
- Lane mispredicts when valid, kind != 3, not suppressed, and true target != pred_tgt.
- Age compare: A is older than B iff (A[ROBID_W-2:0] < B[ROBID_W-2:0]) XOR (A[MSB] != B[MSB]).
- Arbitration: the oldest mispredicting lane wins. Equal robids are illegal; if they occur, the lowest lane index wins.
- FSM:
  - IDLE -> FLUSHING on any issued mispredict. The held register H is set to the winner's robid.
  - FLUSHING: a lane is suppressed (resvld=0, no mispredict) iff its robid is younger than H. A non-suppressed lane that mispredicts and is older than H issues a new redirect and replaces H. The state stays FLUSHING.
  - FLUSHING -> IDLE on flush_done, unless a new redirect issues in the same cycle. In that case the new redirect wins and the state stays FLUSHING with the updated H.
  - flush_done in IDLE is ignored.
- Suppression uses the H value from the start of the cycle. Lanes in the same cycle are not suppressed by each other; arbitration alone picks the redirect.

## Timing
- One-cycle latency: EX0 inputs are registered into all EX1 outputs.
- resvld_ex1[i] = registered (iss_vld & kind!=3 & !suppressed).
- mispred_vld_ex1 is a single-cycle pulse per redirect.
- While mispred_vld_ex1 is 0, mispred_tgt_ex1 and mispred_robid_ex1 hold their last values.
- flushing goes high in the same cycle as mispred_vld_ex1. It falls in the cycle after flush_done is sampled.
- Reset (asynchronous assert, synchronous-to-clk deassert by the top level):
  - all outputs 0, FSM IDLE, H=0.
  - Reset mid-flush abandons H.
- No back-pressure: EX1 outputs are consumed unconditionally.

## Test plan
- Lane0 BEQ, pc=0x1000, imm=0x40, src1=src2=5, pred=0x1004 -> next cycle resvld=01, mispred_vld=1, tgt=0x1040, robid=lane0 id, flushing=1.
- BLT src1=0xFFFF_FFFF_FFFF_FFFF, src2=1 -> taken. BLTU with the same operands -> not taken. pred matching each true target -> no mispredict.
- Two lanes mispredict the same cycle: robid lane0=0x45, lane1=0x03 with wrap bits differing (0x03 is newer after wrap) -> lane0 wins, H=0x45.
- In FLUSHING with H=0x10: lane with robid 0x12 -> resvld=0, no redirect. Lane with robid 0x0E mispredicting -> redirect issued, H=0x0E.
- JALR src1=0x2003, imm=0, pred=0x2002 -> no mispredict, link=pc+4. Same-cycle flush_done plus new older mispredict -> flushing stays 1.
- Reset asserted while FLUSHING -> all outputs 0 asynchronously, FSM IDLE. Next branch with pred=true target produces no redirect.

Source files
------------

// File: rtl/ibr_multi.sv
// ibr_multi: multi-lane integer branch resolution unit (EX0 -> EX1).
// Resolves BR/JAL/JALR per lane and compares each true target with the
// front-end predicted target. It arbitrates the oldest mispredict into a
// registered redirect. While a redirect drains, branches younger than the
// held redirect are suppressed.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   iss_*_ex0             per-lane issue payload (vld/kind/funct3/pc/imm/pred/robid)
//   src1_ex0, src2_ex0    per-lane operands
//   flush_done            ROB pulse: redirect drained
//   resvld_ex1, link_ex1  per-lane result valid and link value
//   mispred_*_ex1         redirect pulse, target and ROB id (held when idle)
//   flushing              flush state indicator
module ibr_multi #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned XLEN      = 64,
  parameter int unsigned PADDR_W   = 64,
  parameter int unsigned ROBID_W   = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LANES-1:0]           iss_vld_ex0,
  input  logic [2*NUM_LANES-1:0]         iss_kind_ex0,
  input  logic [3*NUM_LANES-1:0]         iss_funct3_ex0,
  input  logic [PADDR_W*NUM_LANES-1:0]   iss_pc_ex0,
  input  logic [PADDR_W*NUM_LANES-1:0]   iss_imm_ex0,
  input  logic [PADDR_W*NUM_LANES-1:0]   iss_pred_tgt_ex0,
  input  logic [ROBID_W*NUM_LANES-1:0]   iss_robid_ex0,
  input  logic [XLEN*NUM_LANES-1:0]      src1_ex0,
  input  logic [XLEN*NUM_LANES-1:0]      src2_ex0,
  input  logic                           flush_done,
  output logic [NUM_LANES-1:0]           resvld_ex1,
  output logic [XLEN*NUM_LANES-1:0]      link_ex1,
  output logic                           mispred_vld_ex1,
  output logic [PADDR_W-1:0]             mispred_tgt_ex1,
  output logic [ROBID_W-1:0]             mispred_robid_ex1,
  output logic                           flushing
);

  localparam logic [1:0] KIND_JAL  = 2'd1;
  localparam logic [1:0] KIND_JALR = 2'd2;
  localparam logic [1:0] KIND_RSV  = 2'd3;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t               state_q, state_nxt;
  logic [ROBID_W-1:0]   h_q;
  logic [NUM_LANES-1:0] lane_ok_c;
  logic [XLEN*NUM_LANES-1:0] link_c;
  logic                 any_c;
  logic [ROBID_W-1:0]   win_rob_c;
  logic [PADDR_W-1:0]   win_tgt_c;

  // Wrap-aware age compare: a is older than b.
  function automatic logic is_older(input logic [ROBID_W-1:0] a,
                                    input logic [ROBID_W-1:0] b);
    return (a[ROBID_W-2:0] < b[ROBID_W-2:0]) ^ (a[ROBID_W-1] != b[ROBID_W-1]);
  endfunction

  // Per-lane resolution, suppression and oldest-mispredict arbitration.
  always_comb begin : lane_eval
    logic [PADDR_W-1:0] pc, imm, pred, pcnxt, tgt;
    logic [XLEN-1:0]    s1, s2;
    logic [1:0]         kind;
    logic [2:0]         f3;
    logic [ROBID_W-1:0] rob;
    logic               taken, supp, mis;
    lane_ok_c = '0;
    link_c    = '0;
    any_c     = 1'b0;
    win_rob_c = '0;
    win_tgt_c = '0;
    pc = '0; imm = '0; pred = '0; pcnxt = '0; tgt = '0;
    s1 = '0; s2 = '0; kind = '0; f3 = '0; rob = '0;
    taken = 1'b0; supp = 1'b0; mis = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pc    = iss_pc_ex0[i*PADDR_W +: PADDR_W];
      imm   = iss_imm_ex0[i*PADDR_W +: PADDR_W];
      pred  = iss_pred_tgt_ex0[i*PADDR_W +: PADDR_W];
      s1    = src1_ex0[i*XLEN +: XLEN];
      s2    = src2_ex0[i*XLEN +: XLEN];
      kind  = iss_kind_ex0[i*2 +: 2];
      f3    = iss_funct3_ex0[i*3 +: 3];
      rob   = iss_robid_ex0[i*ROBID_W +: ROBID_W];
      pcnxt = pc + PADDR_W'(4);
      case (f3)
        3'b000:  taken = (s1 == s2);
        3'b001:  taken = (s1 != s2);
        3'b100:  taken = ($signed(s1) <  $signed(s2));
        3'b101:  taken = ($signed(s1) >= $signed(s2));
        3'b110:  taken = (s1 <  s2);
        3'b111:  taken = (s1 >= s2);
        default: taken = 1'b0;
      endcase
      case (kind)
        KIND_JAL:  tgt = pc + imm;
        KIND_JALR: tgt = (PADDR_W'(s1) + imm) & ~PADDR_W'(1);
        default:   tgt = taken ? (pc + imm) : pcnxt;
      endcase
      // Suppression looks only at H from the start of the cycle.
      supp = (state_q == FLUSH) && is_older(h_q, rob);
      lane_ok_c[i] = iss_vld_ex0[i] && (kind != KIND_RSV) && !supp;
      if (lane_ok_c[i] && (kind == KIND_JAL || kind == KIND_JALR))
        link_c[i*XLEN +: XLEN] = XLEN'(pcnxt);
      mis = lane_ok_c[i] && (tgt != pred);
      // Strictly-older replace keeps the lowest lane on equal ids.
      if (mis && (state_q == IDLE || is_older(rob, h_q)) &&
          (!any_c || is_older(rob, win_rob_c))) begin
        any_c     = 1'b1;
        win_rob_c = rob;
        win_tgt_c = tgt;
      end
    end
  end

  // Next flush state: a new redirect outranks a same-cycle flush_done.
  always_comb begin
    state_nxt = state_q;
    if (any_c)
      state_nxt = FLUSH;
    else if (state_q == FLUSH && flush_done)
      state_nxt = IDLE;
  end

  // EX1 registers, held redirect id and flush state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      h_q               <= '0;
      resvld_ex1        <= '0;
      link_ex1          <= '0;
      mispred_vld_ex1   <= 1'b0;
      mispred_tgt_ex1   <= '0;
      mispred_robid_ex1 <= '0;
      flushing          <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      flushing        <= (state_nxt == FLUSH);
      resvld_ex1      <= lane_ok_c;
      link_ex1        <= link_c;
      mispred_vld_ex1 <= any_c;
      if (any_c) begin
        h_q               <= win_rob_c;
        mispred_tgt_ex1   <= win_tgt_c;
        mispred_robid_ex1 <= win_rob_c;
      end
    end
  end

endmodule
